// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage registers.
// Stall counter is optional, enabled by the PIPE_STALL_CNT_EN macro in pipe_stage_elastic.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 16;
    localparam int CTRL_W_DEF = 12;
    localparam int CNT_W_DEF  = 16;

    // Bit positions inside the control bundle carried alongside each instruction
    localparam int WRITE_REG    = 0;
    localparam int WRITE_MEM    = 1;
    localparam int LOAD         = 2;
    localparam int BRANCH       = 3;
    localparam int BNE          = 4;
    localparam int IMM          = 5;
    localparam int ALU_CTRL_LSB = 6;
    localparam int ALU_CTRL_MSB = 8;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of the elastic stage: payload plus control bundle.
// The control half can be cleared on its own so a killed entry never writes state.
module pipe_slot #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);

    // Clearing only touches ctrl; stale payload bits are harmless once ctrl is zero
    always_ff @(posedge clk) begin
        if (rst) begin
            q_data <= '0;
            q_ctrl <= '0;
        end else begin
            if (load)
                q_data <= d_data;
            if (clr)
                q_ctrl <= '0;
            else if (load)
                q_ctrl <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer and flush.
// Define PIPE_STALL_CNT_EN to build the saturating stall counter; otherwise stall_cnt is 0.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t              state;
    logic                accept;
    logic                emit;
    logic                main_load;
    logic                skid_load;
    logic                main_from_skid;
    logic [DATA_W-1:0]   main_d_data;
    logic [CTRL_W-1:0]   main_d_ctrl;
    logic [DATA_W-1:0]   main_data;
    logic [CTRL_W-1:0]   main_ctrl;
    logic [DATA_W-1:0]   skid_data;
    logic [CTRL_W-1:0]   skid_ctrl;

    // in_ready depends only on the state register, never on out_ready
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;
    assign out_data  = main_data;
    assign out_ctrl  = out_valid ? main_ctrl : '0;

    always_comb begin
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: main_load = accept;
            ONE: begin
                if (accept && emit)
                    main_load = 1'b1;
                else if (accept)
                    skid_load = 1'b1;
            end
            TWO: begin
                if (emit) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign main_d_data = main_from_skid ? skid_data : in_data;
    assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

    // Flush outranks every transition; reset outranks flush
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) state <= ONE;
                ONE: begin
                    if (accept && !emit)
                        state <= TWO;
                    else if (!accept && emit)
                        state <= EMPTY;
                end
                TWO: if (emit) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk    (clk),
        .rst    (rst),
        .clr    (flush),
        .load   (main_load),
        .d_data (main_d_data),
        .d_ctrl (main_d_ctrl),
        .q_data (main_data),
        .q_ctrl (main_ctrl)
    );

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .clr    (flush),
        .load   (skid_load),
        .d_data (in_data),
        .d_ctrl (in_ctrl),
        .q_data (skid_data),
        .q_ctrl (skid_ctrl)
    );

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    // Saturating count of downstream back-pressure cycles; flush leaves it alone
    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
            stall_q <= stall_q + 1'b1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic against a queue-based FIFO model.
// Expected stall_cnt follows the PIPE_STALL_CNT_EN macro of the build.
module tb_pipe_stage_elastic;

    localparam int DW = 16;
    localparam int CW = 12;
    localparam int NW = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          flush;
    logic [NW-1:0] stall_cnt;

    ent_t          mq[$];
    logic [NW-1:0] exp_cnt;
    int            checks;
    int            failures;

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are compared against the model's pre-edge view of the FIFO
    task automatic checkOutput(input string tag);
        checkValue({tag, ":out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
        checkValue({tag, ":in_ready"}, 32'(in_ready), 32'(mq.size() < 2));
        if (mq.size() > 0) begin
            checkValue({tag, ":out_data"}, 32'(out_data), 32'(mq[0].d));
            checkValue({tag, ":out_ctrl"}, 32'(out_ctrl), 32'(mq[0].c));
        end else begin
            checkValue({tag, ":out_ctrl_idle"}, 32'(out_ctrl), 32'd0);
        end
        checkValue({tag, ":stall_cnt"}, 32'(stall_cnt), 32'(exp_cnt));
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                                 input logic ordy, input logic fl, input logic r, input string tag);
        logic em, ac, stalled;
        ent_t e;
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        checkOutput(tag);
        em      = (mq.size() > 0) && ordy;
        ac      = v && (mq.size() < 2);
        stalled = (mq.size() > 0) && !ordy;
        @(posedge clk);
        if (r) begin
            mq.delete();
            exp_cnt = '0;
        end else begin
`ifdef PIPE_STALL_CNT_EN
            if (stalled && exp_cnt != {NW{1'b1}})
                exp_cnt = exp_cnt + 1'b1;
`else
            if (stalled)
                exp_cnt = '0;
`endif
            if (fl) begin
                mq.delete();
            end else begin
                if (em)
                    void'(mq.pop_front());
                if (ac) begin
                    e.d = d;
                    e.c = c;
                    mq.push_back(e);
                end
            end
        end
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_cnt   = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Test 1: reset wins over a valid input
        applyStimulus(1'b1, 16'h1234, 12'hABC, 1'b1, 1'b0, 1'b1, "t1_rst");
        checkValue("t1:out_data_zero", 32'(out_data), 32'd0);
        applyStimulus(1'b0, 16'h0000, 12'h000, 1'b1, 1'b0, 1'b0, "t1_idle");

        // Test 2: streaming with no back-pressure
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 16'hA000 + 16'(i), 12'(12'h100 + i), 1'b1, 1'b0, 1'b0, "t2_stream");
        applyStimulus(1'b0, 16'h0000, 12'h000, 1'b1, 1'b0, 1'b0, "t2_drain");
        applyStimulus(1'b0, 16'h0000, 12'h000, 1'b1, 1'b0, 1'b0, "t2_empty");

        // Test 3: fill the skid buffer, then release
        applyStimulus(1'b1, 16'hB000, 12'h801, 1'b0, 1'b0, 1'b0, "t3_fill0");
        applyStimulus(1'b1, 16'hB001, 12'h802, 1'b0, 1'b0, 1'b0, "t3_fill1");
        applyStimulus(1'b1, 16'hB002, 12'h803, 1'b0, 1'b0, 1'b0, "t3_full");
        applyStimulus(1'b1, 16'hB002, 12'h803, 1'b1, 1'b0, 1'b0, "t3_rel0");
        applyStimulus(1'b1, 16'hB002, 12'h803, 1'b1, 1'b0, 1'b0, "t3_rel1");
        applyStimulus(1'b0, 16'h0000, 12'h000, 1'b1, 1'b0, 1'b0, "t3_rel2");
        applyStimulus(1'b0, 16'h0000, 12'h000, 1'b1, 1'b0, 1'b0, "t3_empty");

        // Test 4: flush from the full state with an incoming entry
        applyStimulus(1'b1, 16'hC000, 12'hF01, 1'b0, 1'b0, 1'b0, "t4_fill0");
        applyStimulus(1'b1, 16'hC001, 12'hF02, 1'b0, 1'b0, 1'b0, "t4_fill1");
        applyStimulus(1'b1, 16'hC002, 12'hF03, 1'b0, 1'b1, 1'b0, "t4_flush");
        applyStimulus(1'b0, 16'h0000, 12'h000, 1'b1, 1'b0, 1'b0, "t4_after");
        applyStimulus(1'b0, 16'h0000, 12'h000, 1'b1, 1'b0, 1'b0, "t4_after2");

        // Test 5: flush coinciding with an emit from the main slot
        applyStimulus(1'b1, 16'hD00D, 12'h5A5, 1'b0, 1'b0, 1'b0, "t5_load");
        applyStimulus(1'b0, 16'h0000, 12'h000, 1'b1, 1'b1, 1'b0, "t5_flush_emit");
        applyStimulus(1'b0, 16'h0000, 12'h000, 1'b1, 1'b0, 1'b0, "t5_after");

        // Test 6: long stall drives the counter to saturation
        applyStimulus(1'b1, 16'hE000, 12'h0F0, 1'b0, 1'b0, 1'b0, "t6_load");
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b0, 16'h0000, 12'h000, 1'b0, 1'b0, 1'b0, "t6_stall");
`ifdef PIPE_STALL_CNT_EN
        checkValue("t6:stall_sat", 32'(stall_cnt), 32'h0000_000F);
`else
        checkValue("t6:stall_off", 32'(stall_cnt), 32'd0);
`endif
        applyStimulus(1'b0, 16'h0000, 12'h000, 1'b1, 1'b1, 1'b0, "t6_flush_keeps_cnt");
        applyStimulus(1'b0, 16'h0000, 12'h000, 1'b1, 1'b0, 1'b1, "t6_rst");
        applyStimulus(1'b0, 16'h0000, 12'h000, 1'b1, 1'b0, 1'b0, "t6_after_rst");

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          16'($urandom),
                          12'($urandom),
                          ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 63) == 0),
                          "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
